// File: rtl/pwm_capture_if.sv
// ============================================================================
// Module   : pwm_capture_if
// Brief    : Control and measurement-result bundle of the PWM capture block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_capture_if #(
  parameter int WIDTH = 12
) ();
  logic             en;
  logic             pwm_in;
  logic [WIDTH-1:0] high_width;
  logic [WIDTH-1:0] period;
  logic             sample_valid;
  logic             timeout;
  logic             glitch;
  logic             line_level;

  // master: the capture block; slave: whoever drives the line and consumes results
  modport master (
    input  en, pwm_in,
    output high_width, period, sample_valid, timeout, glitch, line_level
  );

  modport slave (
    output en, pwm_in,
    input  high_width, period, sample_valid, timeout, glitch, line_level
  );
endinterface : pwm_capture_if

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
// Module   : pwm_capture
// Brief    : Measures high time and rise-to-rise period of an async PWM input,
//            flagging lost signal (timeout) and runt pulses (glitch).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_capture #(
  parameter int WIDTH    = 12,
  parameter int TIMEOUT  = 4095,
  parameter int MIN_HIGH = 2
) (
  input  wire               clk,
  input  wire               rst_n,
  pwm_capture_if.master     cap
);

  localparam logic [WIDTH-1:0] C_TIMEOUT  = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] C_MIN_HIGH = WIDTH'(MIN_HIGH);
  localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [WIDTH-1:0] high_width_q, high_width_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             sample_valid_q, sample_valid_d;
  logic             timeout_q, timeout_d;
  logic             glitch_q, glitch_d;

  logic w_rise, w_fall, w_expired;

  assign w_rise    = s2_q & ~s3_q;
  assign w_fall    = ~s2_q & s3_q;
  assign w_expired = (per_cnt_q == C_TIMEOUT);

  // The synchronizer keeps running while disabled so the edge detector is
  // already primed when capture resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= cap.pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      hi_cnt_q       <= '0;
      per_cnt_q      <= '0;
      high_width_q   <= '0;
      period_q       <= '0;
      sample_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      glitch_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      hi_cnt_q       <= hi_cnt_d;
      per_cnt_q      <= per_cnt_d;
      high_width_q   <= high_width_d;
      period_q       <= period_d;
      sample_valid_q <= sample_valid_d;
      timeout_q      <= timeout_d;
      glitch_q       <= glitch_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    hi_cnt_d       = hi_cnt_q;
    per_cnt_d      = per_cnt_q;
    high_width_d   = high_width_q;
    period_d       = period_q;
    sample_valid_d = 1'b0;
    timeout_d      = 1'b0;
    glitch_d       = 1'b0;

    if (!cap.en) begin
      state_d   = ST_IDLE;
      hi_cnt_d  = '0;
      per_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_rise) begin
            hi_cnt_d  = C_ONE;
            per_cnt_d = C_ONE;
            state_d   = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_expired) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
          end else if (w_fall) begin
            if (hi_cnt_q >= C_MIN_HIGH) begin
              per_cnt_d = per_cnt_q + C_ONE;
              state_d   = ST_LOW;
            end else begin
              glitch_d  = 1'b1;
              state_d   = ST_IDLE;
              hi_cnt_d  = '0;
              per_cnt_d = '0;
            end
          end else begin
            hi_cnt_d  = hi_cnt_q + C_ONE;
            per_cnt_d = per_cnt_q + C_ONE;
          end
        end
        ST_LOW: begin
          // A rise on the last allowed cycle still closes a valid period.
          if (w_rise) begin
            high_width_d   = hi_cnt_q;
            period_d       = per_cnt_q;
            sample_valid_d = 1'b1;
            hi_cnt_d       = C_ONE;
            per_cnt_d      = C_ONE;
            state_d        = ST_HIGH;
          end else if (w_expired) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
          end else begin
            per_cnt_d = per_cnt_q + C_ONE;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          hi_cnt_d  = '0;
          per_cnt_d = '0;
        end
      endcase
    end
  end

  assign cap.high_width   = high_width_q;
  assign cap.period       = period_q;
  assign cap.sample_valid = sample_valid_q;
  assign cap.timeout      = timeout_q;
  assign cap.glitch       = glitch_q;
  assign cap.line_level   = s2_q;

endmodule : pwm_capture

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
// Module   : tb_pwm_capture
// Brief    : Scoreboard bench for pwm_capture: expected strobes are queued as
//            the PWM line is driven and popped when the DUT strobes.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pwm_capture;

  localparam int WIDTH     = 12;
  localparam int TIMEOUT   = 4095;
  localparam int MIN_HIGH  = 2;
  localparam int K_SAMPLE  = 1;
  localparam int K_TIMEOUT = 2;
  localparam int K_GLITCH  = 3;

  typedef struct {
    int kind;
    int hw;
    int per;
    int cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  ev_t  exp_q[$];
  bit   armed    = 1'b0;
  int   prev_hw  = 0;
  int   prev_per = 0;
  int   rise_cyc = 0;

  int   mon_n;
  int   mon_kind;
  ev_t  mon_e;

  pwm_capture_if #(.WIDTH(WIDTH)) cap ();

  pwm_capture #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT),
    .MIN_HIGH(MIN_HIGH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cap  (cap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int kind, input int hw, input int per, input int c);
    ev_t e;
    e.kind = kind;
    e.hw   = hw;
    e.per  = per;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  // Rising input edge: closes the previous period if capture was running.
  task automatic start_rise();
    @(posedge clk);
    #2;
    cap.pwm_in = 1'b1;
    rise_cyc   = cyc;
    if (armed) push_ev(K_SAMPLE, prev_hw, prev_per, cyc + 3);
  endtask

  task automatic drive_period(input int h, input int p);
    start_rise();
    prev_hw  = h;
    prev_per = p;
    armed    = 1'b1;
    repeat (h) @(posedge clk);
    #2;
    cap.pwm_in = 1'b0;
    repeat (p - h - 1) @(posedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_hw"},    int'(cap.high_width),   0);
    check({tag, "_per"},   int'(cap.period),       0);
    check({tag, "_valid"}, int'(cap.sample_valid), 0);
    check({tag, "_tmo"},   int'(cap.timeout),      0);
    check({tag, "_glt"},   int'(cap.glitch),       0);
    check({tag, "_lvl"},   int'(cap.line_level),   0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_n = int'(cap.sample_valid) + int'(cap.timeout) + int'(cap.glitch);
      if (mon_n > 0) begin
        mon_kind = cap.sample_valid ? K_SAMPLE : (cap.timeout ? K_TIMEOUT : K_GLITCH);
        check("strobe_excl", mon_n, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", mon_kind, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind", mon_kind, mon_e.kind);
          check("strobe_cyc", cyc, mon_e.cyc);
          if (mon_e.kind == K_SAMPLE) begin
            check("high_width", int'(cap.high_width), mon_e.hw);
            check("period", int'(cap.period), mon_e.per);
          end
        end
      end
    end
  end

  initial begin
    cap.en     = 1'b1;
    cap.pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Steady 150/3127 stream, then a compare change to 300.
    repeat (3) drive_period(150, 3127);
    repeat (2) drive_period(300, 3127);

    // Line stops low after one more rise: sample, then loss-of-signal.
    start_rise();
    armed = 1'b0;
    push_ev(K_TIMEOUT, 0, 0, rise_cyc + TIMEOUT + 3);
    repeat (300) @(posedge clk);
    #2;
    cap.pwm_in = 1'b0;
    repeat (4200) @(posedge clk);
    #1;
    check("tmo_hold_hw", int'(cap.high_width), 300);
    check("tmo_hold_per", int'(cap.period), 3127);

    // Runt pulse from idle, then a clean 100/1000 waveform.
    @(posedge clk);
    #2;
    cap.pwm_in = 1'b1;
    push_ev(K_GLITCH, 0, 0, cyc + 4);
    @(posedge clk);
    #2;
    cap.pwm_in = 1'b0;
    repeat (20) @(posedge clk);
    repeat (3) drive_period(100, 1000);
    drive_period(150, 3127);

    // Asynchronous reset in the middle of a high phase.
    start_rise();
    armed = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("line_level_high", int'(cap.line_level), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    repeat (100) @(posedge clk);
    #2;
    cap.pwm_in = 1'b0;
    repeat (300) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check_outputs_zero("rst_release");
    repeat (20) @(posedge clk);
    repeat (3) drive_period(150, 3127);

    // Capture disabled for 500 cycles in the low phase of a period.
    start_rise();
    armed = 1'b0;
    repeat (150) @(posedge clk);
    #2;
    cap.pwm_in = 1'b0;
    repeat (850) @(posedge clk);
    #2;
    cap.en = 1'b0;
    repeat (500) @(posedge clk);
    #2;
    cap.en = 1'b1;
    #1;
    check("en_hold_hw", int'(cap.high_width), 150);
    check("en_hold_per", int'(cap.period), 3127);
    repeat (1626) @(posedge clk);
    repeat (3) drive_period(150, 3127);

    repeat (10) @(posedge clk);
    check("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pwm_capture

`default_nettype wire
